pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register; successor to the fixed-field stage registers between ID/EXE/MEM/WB.
//  Carries one opaque DATA_W-bit payload (control fields packed by the producing stage) with valid/ready handshake.
//  Adds a 2-entry skid buffer so a registered in_ready still gives full throughput. Keeps flush/freeze semantics.
// PARAMETERS
//  DATA_W        32  payload width in bits (>=1)
//  CLEAR_DATA    1   1: payload regs zeroed on reset/flush; 0: only valid bits cleared (payload keeps old value)
//  RESET_DATA    0   payload value loaded on reset/flush when CLEAR_DATA=1 (DATA_W bits)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  flush       in   1       discard all held entries and the current input
//  freeze      in   1       hold all state; no accept, no emit
//  in_valid    in   1       upstream payload valid
//  in_ready    out  1       stage can accept (registered)
//  in_data     in   DATA_W  upstream payload
//  out_valid   out  1       downstream payload valid
//  out_ready   in   1       downstream accepts
//  out_data    out  DATA_W  payload to downstream (registered, no comb path from in_data)
//  occupancy   out  2       entries held: 0,1,2
//  stall_cnt   out  32      [PIPE_STAGE_PERF_EN only] cycles with out_valid&!out_ready
//  bubble_cnt  out  32      [PIPE_STAGE_PERF_EN only] cycles with !out_valid, excluding freeze
// BEHAVIOUR
//  - Storage: main slot (drives out_data) + skid slot; occupancy = main_v + skid_v.
//  - Reset (async, rst=1): main_v=skid_v=0; in_ready=1; out_valid=0; occupancy=0; payload per CLEAR_DATA; perf counters 0.
//  - Handshakes: accept = in_valid & in_ready & ~freeze & ~flush; emit = out_valid & out_ready (out_valid already 0 in freeze).
//  - out_valid = main_v & ~freeze. in_ready = ~skid_v (registered), gated to 0 while freeze=1.
//  - Latency: empty stage, accept at edge N -> out_valid=1, out_data=payload after edge N. Throughput 1/cycle.
//  - Per edge, priority flush > freeze > normal:
//    flush: main_v,skid_v <- 0; input dropped; in_ready=1 next cycle. Applies even when freeze=1.
//    freeze: every register holds; in_data ignored.
//    normal, occupancy 0: accept -> main.
//    normal, occupancy 1: emit&accept -> main<=in; emit only -> empty; accept only -> skid<=in (occ 2, in_ready drops).
//    normal, occupancy 2: accept impossible; emit -> main<=skid, skid_v<=0 (in_ready=1 next cycle).
//  - Ordering strictly FIFO; no payload duplicated or lost except on flush/reset.
//  - Reset asserted mid-transfer: all entries lost, no partial state; first accept after rst release behaves as empty.
//  - in_data may change or be X while in_valid=0; never sampled then.
// CONFIGURATION
//  - Macro PIPE_STAGE_PERF_EN defined: stall_cnt/bubble_cnt ports exist; 32-bit, saturate at 0xFFFF_FFFF.
//    Cleared by rst only (not by flush); hold during freeze.
//  - Macro undefined: both ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package pipe_pkg: typedef occ_t (2-bit); localparams OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2;
//    PERF_CNT_W=32.
//  - One sub-module: pipe_sat_counter (WIDTH, inc, clr-by-rst, saturating), instantiated twice under PIPE_STAGE_PERF_EN.
//  - Slot control is a small explicit occupancy FSM (EMPTY/ONE/FULL) in this module.
// TESTING
//  - Reset: rst=1 mid-traffic with occ=2 -> same cycle out_valid=0, occupancy=0; after release in_ready=1.
//  - Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive edges -> out_data 0x11,0x22,0x33 one cycle later each, occ stays 1.
//  - Backpressure: out_ready=0, push 0xA,0xB -> occ=2, in_ready=0; push 0xC held off; out_ready=1 -> emits 0xA,0xB,0xC in order.
//  - Freeze: occ=1 holding 0x55, freeze=1 for 3 cycles with in_valid=1,in_data=0x66 -> out_valid=0, in_ready=0, occ=1;
//    release -> 0x55 emitted, then 0x66.
//  - Flush vs freeze: occ=2, freeze=1 & flush=1 same edge -> occ=0, out_valid=0, in_data dropped; CLEAR_DATA=1 -> out_data=RESET_DATA.
//  - PERF_EN: out_ready=0 with 1 entry for 5 cycles -> stall_cnt=5; 4 idle cycles + 2 frozen -> bubble_cnt=4; flush leaves counts.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register (pipe_stage_reg).
package pipe_pkg;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

   localparam int unsigned PERF_CNT_W = 32;

   // State encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones, cleared only by rst.
module pipe_sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_r;
   logic             at_max_s;

   assign at_max_s = &cnt_r;
   assign cnt      = cnt_r;

   // Count register with saturation at the maximum value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (inc && !at_max_s) begin
         cnt_r <= cnt_r + WIDTH'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, flush/freeze control.
// Optional performance counters enabled by macro PIPE_STAGE_PERF_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W     = 32,
   parameter bit                CLEAR_DATA = 1'b1,
   parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

   occ_state_e        state_r;
   logic              main_v_s;
   logic              skid_v_s;
   logic              accept_s;
   logic              emit_s;
   logic [DATA_W-1:0] main_data_r;
   logic [DATA_W-1:0] skid_data_r;
   logic [DATA_W-1:0] main_data_s;
   logic [DATA_W-1:0] skid_data_s;

   assign main_v_s  = (state_r == ST_ONE) || (state_r == ST_FULL);
   assign skid_v_s  = (state_r == ST_FULL);
   assign out_valid = main_v_s & ~freeze;
   assign in_ready  = ~skid_v_s & ~freeze;
   assign accept_s  = in_valid & in_ready & ~flush;
   assign emit_s    = out_valid & out_ready;
   assign occupancy = state_r;
   assign out_data  = main_data_r;

   // Occupancy FSM: flush beats freeze, freeze holds, otherwise track accepts and emits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_EMPTY;
      end else if (flush) begin
         state_r <= ST_EMPTY;
      end else if (freeze) begin
         state_r <= state_r;
      end else begin
         case (state_r)
            ST_EMPTY: state_r <= accept_s ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
               if (emit_s && !accept_s) begin
                  state_r <= ST_EMPTY;
               end else if (accept_s && !emit_s) begin
                  state_r <= ST_FULL;
               end else begin
                  state_r <= ST_ONE;
               end
            end
            ST_FULL:  state_r <= emit_s ? ST_ONE : ST_FULL;
            default:  state_r <= ST_EMPTY;
         endcase
      end
   end

   // Next payload for main and skid slots; skid only fills when main is held downstream
   always_comb begin
      main_data_s = main_data_r;
      skid_data_s = skid_data_r;
      if (flush && CLEAR_DATA) begin
         main_data_s = RESET_DATA;
         skid_data_s = RESET_DATA;
      end else if (rst || flush || freeze) begin
         main_data_s = main_data_r;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  main_data_s = in_data;
               end else begin
                  main_data_s = main_data_r;
               end
            end
            ST_ONE: begin
               if (accept_s && emit_s) begin
                  main_data_s = in_data;
               end else if (accept_s) begin
                  skid_data_s = in_data;
               end else begin
                  main_data_s = main_data_r;
               end
            end
            ST_FULL: begin
               if (emit_s) begin
                  main_data_s = skid_data_r;
               end else begin
                  main_data_s = main_data_r;
               end
            end
            default: begin
               main_data_s = main_data_r;
            end
         endcase
      end
   end

   generate
      if (CLEAR_DATA) begin : g_clear_data
         // Payload registers reset to RESET_DATA
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               main_data_r <= RESET_DATA;
               skid_data_r <= RESET_DATA;
            end else begin
               main_data_r <= main_data_s;
               skid_data_r <= skid_data_s;
            end
         end
      end else begin : g_keep_data
         // Payload registers without reset; old contents survive reset and flush
         always_ff @(posedge clk) begin
            main_data_r <= main_data_s;
            skid_data_r <= skid_data_s;
         end
      end
   endgenerate

`ifdef PIPE_STAGE_PERF_EN
   logic stall_inc_s;
   logic bubble_inc_s;

   // out_valid is already low while frozen, so both counters hold during freeze
   assign stall_inc_s  = out_valid & ~out_ready;
   assign bubble_inc_s = ~out_valid & ~freeze;

   pipe_sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc_s),
      .cnt (stall_cnt)
   );

   pipe_sat_counter #(.WIDTH(PERF_CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bubble_inc_s),
      .cnt (bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// checked against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_reg;

   localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        freeze;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] q[$];
   int unsigned m_stall;
   int unsigned m_bubble;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W     (32),
      .CLEAR_DATA (1'b1),
      .RESET_DATA (RST_VAL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .freeze     (freeze),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   // Advance one rising edge and update the FIFO model from the pre-edge inputs.
   task automatic step();
      logic ov, ir, acc, em;
      ov  = (q.size() != 0) && !freeze;
      ir  = (q.size() < 2) && !freeze;
      acc = in_valid && ir && !flush;
      em  = ov && out_ready;
      @(posedge clk);
      if (!rst) begin
         if (ov && !out_ready) m_stall++;
         if (!ov && !freeze) m_bubble++;
         if (flush) begin
            q.delete();
         end else if (!freeze) begin
            if (em) void'(q.pop_front());
            if (acc) q.push_back(in_data);
         end
      end
      #1;
   endtask

   task automatic do_reset_assert();
      rst = 1'b1;
      #1;
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
   endtask

   task automatic do_reset_release();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      do_reset_assert();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_data !== RST_VAL) $display("FAIL reset_out_data: got %h want %h", out_data, RST_VAL); else pass_cnt++;
      do_reset_release();
   endtask

   task automatic test_streaming();
      logic [31:0] exp;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp     = 32'h11 * (i + 1);
         in_data = exp;
         step();
         total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_valid%0d: got %b want 1", i, out_valid); else pass_cnt++;
         total_cnt++; if (out_data !== exp) $display("FAIL stream_data%0d: got %h want %h", i, out_data, exp); else pass_cnt++;
         total_cnt++; if (occupancy !== 2'd1) $display("FAIL stream_occ%0d: got %0d want 1", i, occupancy); else pass_cnt++;
      end
      in_valid = 1'b0;
      step();
      total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL stream_drain: got occ=%0d valid=%b want 0/0", occupancy, out_valid); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA; step();
      in_data   = 32'hB; step();
      total_cnt++; if (occupancy !== 2'd2) $display("FAIL bp_occ_full: got %0d want 2", occupancy); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else pass_cnt++;
      in_data = 32'hC; step(); step();
      total_cnt++; if (occupancy !== 2'd2 || out_data !== 32'hA) $display("FAIL bp_hold: got occ=%0d data=%h want 2/a", occupancy, out_data); else pass_cnt++;
      out_ready = 1'b1;
      #1;
      total_cnt++; if (out_data !== 32'hA) $display("FAIL bp_emit0: got %h want a", out_data); else pass_cnt++;
      step();
      total_cnt++; if (out_data !== 32'hB || in_ready !== 1'b1) $display("FAIL bp_emit1: got data=%h rdy=%b want b/1", out_data, in_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_data !== 32'hC || out_valid !== 1'b1) $display("FAIL bp_emit2: got data=%h valid=%b want c/1", out_data, out_valid); else pass_cnt++;
      in_valid = 1'b0;
      step();
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL bp_drain: got %0d want 0", occupancy); else pass_cnt++;
   endtask

   task automatic test_freeze();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      step();
      in_data = 32'h66;
      freeze  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++; if (out_valid !== 1'b0) $display("FAIL frz_valid%0d: got %b want 0", i, out_valid); else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b0) $display("FAIL frz_ready%0d: got %b want 0", i, in_ready); else pass_cnt++;
         total_cnt++; if (occupancy !== 2'd1) $display("FAIL frz_occ%0d: got %0d want 1", i, occupancy); else pass_cnt++;
         step();
      end
      freeze    = 1'b0;
      out_ready = 1'b1;
      #1;
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h55) $display("FAIL frz_rel0: got valid=%b data=%h want 1/55", out_valid, out_data); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h66) $display("FAIL frz_rel1: got valid=%b data=%h want 1/66", out_valid, out_data); else pass_cnt++;
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_flush_freeze();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h77; step();
      in_data   = 32'h88; step();
      in_data   = 32'h99;
      freeze    = 1'b1;
      flush     = 1'b1;
      step();
      freeze   = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_state: got occ=%0d valid=%b want 0/0", occupancy, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== RST_VAL) $display("FAIL flush_data: got %h want %h", out_data, RST_VAL); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready); else pass_cnt++;
      step();
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL flush_dropped: got %0d want 0", occupancy); else pass_cnt++;
   endtask

   task automatic test_reset_midtraffic();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1234; step();
      in_data   = 32'h5678; step();
      total_cnt++; if (occupancy !== 2'd2) $display("FAIL rstmid_pre: got %0d want 2", occupancy); else pass_cnt++;
      do_reset_assert();
      total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL rstmid_now: got valid=%b occ=%0d want 0/0", out_valid, occupancy); else pass_cnt++;
      do_reset_release();
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", in_ready); else pass_cnt++;
      in_data = 32'h9ABC;
      step();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h9ABC || occupancy !== 2'd1) $display("FAIL rstmid_first: got valid=%b data=%h occ=%0d want 1/9abc/1", out_valid, out_data, occupancy); else pass_cnt++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
   endtask

`ifdef PIPE_STAGE_PERF_EN
   task automatic test_perf();
      out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0; freeze = 1'b0;
      do_reset_assert();
      do_reset_release();
      for (int i = 0; i < 4; i++) step();
      freeze = 1'b1;
      step(); step();
      freeze = 1'b0;
      #1;
      total_cnt++; if (bubble_cnt !== 32'd4) $display("FAIL perf_bubble: got %0d want 4", bubble_cnt); else pass_cnt++;
      total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL perf_stall0: got %0d want 0", stall_cnt); else pass_cnt++;
      in_valid = 1'b1; in_data = 32'h42;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      total_cnt++; if (stall_cnt !== 32'd5) $display("FAIL perf_stall: got %0d want 5", stall_cnt); else pass_cnt++;
      out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      total_cnt++; if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd5) $display("FAIL perf_flush: got stall=%0d bubble=%0d want 5/5", stall_cnt, bubble_cnt); else pass_cnt++;
   endtask
`endif

   task automatic test_random();
      int errs;
      errs = 0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         in_data   = $urandom();
         out_ready = ($urandom_range(0, 9) < 6);
         freeze    = ($urandom_range(0, 9) == 0);
         flush     = ($urandom_range(0, 19) == 0);
         #1;
         total_cnt++;
         if (out_valid !== ((q.size() != 0) && !freeze) ||
             in_ready !== ((q.size() < 2) && !freeze) ||
             occupancy !== 2'(q.size()) ||
             ((q.size() != 0) && out_data !== q[0])) begin
            if (errs < 10) $display("FAIL rand_cyc%0d: got valid=%b rdy=%b occ=%0d data=%h want model_occ=%0d head=%h",
                                    c, out_valid, in_ready, occupancy, out_data, q.size(), (q.size() != 0) ? q[0] : 32'h0);
            errs++;
         end else begin
            pass_cnt++;
         end
`ifdef PIPE_STAGE_PERF_EN
         total_cnt++;
         if (stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
            if (errs < 10) $display("FAIL rand_perf%0d: got stall=%0d bubble=%0d want %0d/%0d", c, stall_cnt, bubble_cnt, m_stall, m_bubble);
            errs++;
         end else begin
            pass_cnt++;
         end
`endif
         step();
      end
      flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_freeze();
      test_flush_freeze();
      test_reset_midtraffic();
`ifdef PIPE_STAGE_PERF_EN
      test_perf();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
